clock_route_switch_ctrl: RTL
============================

// Module: clock_route_switch_ctrl
//
// PURPOSE
//   Sequencing controller for an N-source clock route built from clock_cell_mux/
//   clock_cell_buf cells. Accepts a source-select request and performs a
//   glitch-safe switchover: gate the route off, hold, change mux select, settle,
//   gate back on. Outputs drive the select of the source mux tree and the enable
//   of the output gate/mux. Runs entirely in one control-clock domain.
//
// PARAMETERS
//   NUM_SRC        4                  number of selectable clock sources (>=2)
//   SEL_W          $clog2(NUM_SRC)    width of select fields
//   DEFAULT_SEL    0                  route_sel value after reset (< NUM_SRC)
//   GATE_CYCLES    2                  edges route_enable is low before select changes (>=1)
//   SETTLE_CYCLES  4                  edges after select change before re-enable (>=1)
//   CNT_W          8                  wait-counter width; must hold max(GATE,SETTLE)
//
// PORTS
//   clk           in   1      control clock
//   rst_n         in   1      asynchronous active-low reset
//   req_valid     in   1      switch request valid
//   req_ready     out  1      high only in IDLE; request accepted on valid&&ready
//   req_sel       in   SEL_W  requested source index
//   route_sel     out  SEL_W  registered select to source mux tree
//   route_enable  out  1      registered enable to output gate/mux
//   busy          out  1      high in any state except IDLE
//   done          out  1      one-cycle pulse: request completed (incl. no-op)
//   err_sel       out  1      one-cycle pulse: accepted req_sel >= NUM_SRC, ignored
//
// BEHAVIOUR
//   - All outputs registered. Reset (async assert, sync release by integrator):
//     route_sel=DEFAULT_SEL, route_enable=0, done=0, err_sel=0, state=SETTLE,
//     counter=0, req_ready=0, busy=1.
//   - States: IDLE, GATE_OFF, SWITCH, SETTLE.
//   - Post-reset SETTLE: after SETTLE_CYCLES edges -> IDLE, route_enable=1, no done.
//   - IDLE, accept with req_sel==route_sel: stay IDLE, done pulse next cycle,
//     route_enable untouched.
//   - IDLE, accept with req_sel>=NUM_SRC: stay IDLE, err_sel pulse next cycle,
//     no done, outputs untouched.
//   - IDLE, accept valid new sel (edge E0): latch target; route_enable=0 after E0;
//     -> GATE_OFF, counter counts GATE_CYCLES edges total since E0.
//   - GATE_OFF -> SWITCH: route_sel=target after edge E0+GATE_CYCLES.
//   - SWITCH -> SETTLE (single state cycle, counted within SETTLE window).
//   - SETTLE -> IDLE: after edge E0+GATE_CYCLES+SETTLE_CYCLES, route_enable=1,
//     done=1 for one cycle, req_ready=1 same cycle.
//   - route_enable and route_sel never change on the same edge; route_sel only
//     changes while route_enable==0.
//   - req_valid/req_sel ignored while busy; requester must hold until ready.
//   - Counter saturates/clears on state entry; no wrap within a state.
//   - Reset mid-operation: immediate return to reset values, target discarded,
//     full post-reset SETTLE sequence replayed.
//
// TESTING
//   1. Release reset, defaults -> route_sel=0, route_enable=0 for 4 edges, then
//      enable=1, req_ready=1, no done pulse.
//   2. req_sel=2 accepted at E0 -> enable=0 after E0, route_sel=2 after E0+2,
//      enable=1 and done=1 after E0+6; done lasts exactly one cycle.
//   3. req_sel==current (2) -> done next cycle, route_enable stays 1, busy stays 0.
//   4. NUM_SRC=3, req_sel=3 -> err_sel one-cycle pulse, route_sel/enable unchanged.
//   5. req_valid held with req_sel=1 during a 0->3 switch -> 3 completes first,
//      1 accepted on the done cycle, second switch follows with same timing.
//   6. rst_n low at E0+3 of 0->2 switch -> route_sel=0, enable=0 immediately;
//      after release, post-reset settle only, route never reaches 2.

Source files
------------

// File: rtl/clock_route_switch_ctrl.sv
// Sequencing controller for a glitch-safe clock source switchover.
// Gates the route off, changes the mux select, waits for it to settle, then re-enables.
module clock_route_switch_ctrl #(
   parameter int NUM_SRC       = 4,
   parameter int SEL_W         = $clog2(NUM_SRC),
   parameter int DEFAULT_SEL   = 0,
   parameter int GATE_CYCLES   = 2,
   parameter int SETTLE_CYCLES = 4,
   parameter int CNT_W         = 8
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_req_valid,
   output logic             o_req_ready,
   input  logic [SEL_W-1:0] i_req_sel,
   output logic [SEL_W-1:0] o_route_sel,
   output logic             o_route_enable,
   output logic             o_busy,
   output logic             o_done,
   output logic             o_err_sel
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      GATE_OFF = 2'd1,
      SWITCH   = 2'd2,
      SETTLE   = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] GATE_LAST     = CNT_W'(GATE_CYCLES - 1);
   localparam logic [CNT_W-1:0] SETTLE_LAST   = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [SEL_W:0]   NUM_SRC_W     = (SEL_W + 1)'(NUM_SRC);
   localparam logic [SEL_W-1:0] DEFAULT_SEL_W = SEL_W'(DEFAULT_SEL);
   localparam bit               SWITCH_IS_END = (SETTLE_CYCLES == 1);

   state_t           r_state;
   logic [CNT_W-1:0] r_count;
   logic [SEL_W-1:0] r_target;
   logic             r_postReset;
   logic [SEL_W-1:0] r_routeSel;
   logic             r_routeEnable;
   logic             r_reqReady;
   logic             r_busy;
   logic             r_done;
   logic             r_errSel;

   logic             w_accept;
   logic             w_selInvalid;
   logic             w_selSame;
   logic [CNT_W-1:0] w_countInc;

   assign w_accept     = i_req_valid && r_reqReady;
   assign w_selInvalid = {1'b0, i_req_sel} >= NUM_SRC_W;
   assign w_selSame    = (i_req_sel == r_routeSel);
   assign w_countInc   = (r_count == '1) ? r_count : r_count + CNT_W'(1);

   // The SWITCH edge already counts toward the settle window, so SETTLE is
   // entered from SWITCH with the counter preloaded to 1; after reset it starts at 0.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state       <= SETTLE;
         r_count       <= '0;
         r_target      <= DEFAULT_SEL_W;
         r_postReset   <= 1'b1;
         r_routeSel    <= DEFAULT_SEL_W;
         r_routeEnable <= 1'b0;
         r_reqReady    <= 1'b0;
         r_busy        <= 1'b1;
         r_done        <= 1'b0;
         r_errSel      <= 1'b0;
      end else begin
         r_done   <= 1'b0;
         r_errSel <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  if (w_selInvalid) begin
                     r_errSel <= 1'b1;
                  end else if (w_selSame) begin
                     r_done <= 1'b1;
                  end else begin
                     r_target      <= i_req_sel;
                     r_routeEnable <= 1'b0;
                     r_reqReady    <= 1'b0;
                     r_busy        <= 1'b1;
                     r_count       <= '0;
                     r_state       <= GATE_OFF;
                  end
               end
            end
            GATE_OFF: begin
               if (r_count == GATE_LAST) begin
                  r_routeSel <= r_target;
                  r_count    <= '0;
                  r_state    <= SWITCH;
               end else begin
                  r_count <= w_countInc;
               end
            end
            SWITCH: begin
               if (SWITCH_IS_END) begin
                  r_routeEnable <= 1'b1;
                  r_reqReady    <= 1'b1;
                  r_busy        <= 1'b0;
                  r_done        <= 1'b1;
                  r_count       <= '0;
                  r_state       <= IDLE;
               end else begin
                  r_count <= CNT_W'(1);
                  r_state <= SETTLE;
               end
            end
            SETTLE: begin
               // Only a real switchover reports done; the post-reset settle does not.
               if (r_count == SETTLE_LAST) begin
                  r_routeEnable <= 1'b1;
                  r_reqReady    <= 1'b1;
                  r_busy        <= 1'b0;
                  r_done        <= !r_postReset;
                  r_postReset   <= 1'b0;
                  r_count       <= '0;
                  r_state       <= IDLE;
               end else begin
                  r_count <= w_countInc;
               end
            end
            default: begin
               r_state <= SETTLE;
               r_count <= '0;
            end
         endcase
      end
   end

   assign o_req_ready    = r_reqReady;
   assign o_route_sel    = r_routeSel;
   assign o_route_enable = r_routeEnable;
   assign o_busy         = r_busy;
   assign o_done         = r_done;
   assign o_err_sel      = r_errSel;

endmodule
